// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the 4-bit LFSR generator and its
//                sequence checker: word width, feedback tap mask, checker
//                lock-state encoding and the one-step LFSR next-state function.
//  Contents    : LFSR_WIDTH, LFSR_TAPS, lock_state_e, lfsr_next()
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int              LFSR_WIDTH = 4;
    // x^4 + x^3 + 1: feedback is the XOR of the two most significant bits
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 4'b1100;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } lock_state_e;

    // Fibonacci left shift: the feedback bit enters at the LSB.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] state
    );
        return {state[LFSR_WIDTH-2:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_seq_checker
//  Description : PRBS checker for the lfsr_4bit output. Seeds a local
//                predictor from the received stream, confirms LOCK_CNT
//                consecutive correct predictions, then free-runs (flywheel)
//                and flags/counts every mismatch. ERR_LIMIT consecutive
//                mismatches while locked drop the checker back to HUNT.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-low reset
//                in_valid   - in_data carries a sample this cycle
//                in_data    - received LFSR word
//                clear_cnt  - synchronous clear of err_count
//                locked     - checker is in LOCKED
//                lock_state - 00 HUNT, 01 SYNC, 10 LOCKED
//                err_pulse  - one-cycle pulse per locked-state mismatch
//                err_count  - saturating count of locked-state mismatches
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = LFSR_TAPS,
    parameter int               LOCK_CNT  = 3,
    parameter int               ERR_LIMIT = 4,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic [1:0]       lock_state,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = (LOCK_CNT  > 1) ? $clog2(LOCK_CNT + 1)  : 1;
    localparam int MISS_W  = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;

    // Run counters are compared against "one short of the limit" so the
    // transition happens on the sample that completes the run.
    localparam logic [MATCH_W-1:0] c_MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  c_MISS_LAST  = MISS_W'(ERR_LIMIT - 1);

    lock_state_e        state_q, state_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [MATCH_W-1:0] match_run_q, match_run_d;
    logic [MISS_W-1:0]  miss_run_q, miss_run_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]   w_next_in;   // successor of the received word (reseed)
    logic [WIDTH-1:0]   w_next_exp;  // successor of the prediction (flywheel)
    logic               w_match;
    logic               w_in_nz;

    // ------------------------------------------------------------------
    // Predictor: the package function is the single polynomial source for
    // the default configuration; other widths/taps use the same shift form.
    // ------------------------------------------------------------------
    generate
        if ((WIDTH == LFSR_WIDTH) && (TAPS == WIDTH'(LFSR_TAPS))) begin : g_pkg_poly
            assign w_next_in  = lfsr_next(in_data);
            assign w_next_exp = lfsr_next(exp_q);
        end else begin : g_param_poly
            assign w_next_in  = {in_data[WIDTH-2:0], ^(in_data & TAPS)};
            assign w_next_exp = {exp_q[WIDTH-2:0],   ^(exp_q   & TAPS)};
        end
    endgenerate

    assign w_match = (in_data == exp_q);
    // All-zero is the LFSR lock-up word and can never seed a valid sequence.
    assign w_in_nz = |in_data;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (w_in_nz) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        if (match_run_q == c_MATCH_LAST) begin
                            state_d = LOCKED;
                        end
                    end else if (!w_in_nz) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (!w_match && (miss_run_q == c_MISS_LAST)) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Predictor, run counters and error bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        exp_d       = exp_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (w_in_nz) begin
                        exp_d       = w_next_in;
                        match_run_d = '0;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        exp_d       = w_next_in;
                        match_run_d = match_run_q + MATCH_W'(1);
                        if (match_run_q == c_MATCH_LAST) begin
                            miss_run_d = '0;
                        end
                    end else if (w_in_nz) begin
                        // Wrong but usable word: restart prediction from it.
                        exp_d       = w_next_in;
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from itself, never from
                    // the received data, so a corrupted word does not derail it.
                    exp_d = w_next_exp;
                    if (w_match) begin
                        miss_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_run_d  = miss_run_q + MISS_W'(1);
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // Clear dominates a coincident increment.
        if (clear_cnt) begin
            err_count_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from registers
    // ------------------------------------------------------------------
    always_comb begin
        locked     = (state_q == LOCKED);
        lock_state = state_q;
        err_pulse  = err_pulse_q;
        err_count  = err_count_q;
    end

endmodule : lfsr_seq_checker
`default_nettype wire
